// File: rtl/router_pkg.sv
// Shared types for the packet-router control FSM: state encoding and
// destination address constants.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    CHECK_PARITY_ERROR = 3'd4,
    FIFO_FULL_STATE    = 3'd5,
    LOAD_AFTER_FULL    = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_e;

  localparam logic [1:0] ADDR_0       = 2'b00;
  localparam logic [1:0] ADDR_1       = 2'b01;
  localparam logic [1:0] ADDR_2       = 2'b10;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Per-port flag lookup; address 3 has no port and always reads as 0.
  function automatic logic port_bit(input logic [2:0] flags, input logic [1:0] addr);
    case (addr)
      ADDR_0:  port_bit = flags[0];
      ADDR_1:  port_bit = flags[1];
      ADDR_2:  port_bit = flags[2];
      default: port_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Control FSM of a 3-port packet router: decodes the header address, sequences
// payload/parity loads and stalls on FIFO full or on a non-empty destination.
module router_fsm
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] soft_reset,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic [2:0] dbg_state_o
);

  state_e     state_q, state_d;
  logic [1:0] addr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= ADDR_0;
    end else begin
      state_q <= state_d;
      // The destination is captured only when a header is accepted.
      if (state_q == DECODE_ADDRESS && state_d != DECODE_ADDRESS)
        addr_q <= data_in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && data_in != ADDR_INVALID)
          state_d = port_bit(fifo_empty, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      LOAD_PARITY:         state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:  state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      FIFO_FULL_STATE:     state_d = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      WAIT_TILL_EMPTY: begin
        if (port_bit(fifo_empty, addr_q)) state_d = LOAD_FIRST_DATA;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    // A synchronizer timeout on the active port abandons the packet.
    if (port_bit(soft_reset, addr_q))
      state_d = DECODE_ADDRESS;
  end

  always_comb begin
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    full_state    = (state_q == FIFO_FULL_STATE);
    rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                    (state_q == LOAD_AFTER_FULL);
    busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: a table of per-cycle input vectors with
// the expected next state, scored through an expected queue.
module tb_router_fsm;
  import router_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       busy, detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, write_enb_reg;
  logic [2:0] dbg_state_o;

  router_fsm dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // {state, busy, detect_add, lfd, ld, laf, full, rst_int, wen}
  localparam int W = 11;

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       ff;
    logic [2:0] fe;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    state_e     exp;
  } vec_t;

  vec_t           tbl[$];
  logic [W-1:0]   exp_q[$];
  int             checks = 0;
  int             errors = 0;

  function automatic logic [W-1:0] expect_word(input state_e s);
    logic b, da, lf, ld, la, fu, ri, we;
    b = 1'b1; da = 1'b0; lf = 1'b0; ld = 1'b0;
    la = 1'b0; fu = 1'b0; ri = 1'b0; we = 1'b0;
    case (s)
      DECODE_ADDRESS:     begin b = 1'b0; da = 1'b1; end
      LOAD_FIRST_DATA:    lf = 1'b1;
      LOAD_DATA:          begin b = 1'b0; ld = 1'b1; we = 1'b1; end
      LOAD_PARITY:        we = 1'b1;
      CHECK_PARITY_ERROR: ri = 1'b1;
      FIFO_FULL_STATE:    fu = 1'b1;
      LOAD_AFTER_FULL:    begin la = 1'b1; we = 1'b1; end
      default:            ;
    endcase
    return {3'(s), b, da, lf, ld, la, fu, ri, we};
  endfunction

  function automatic logic [W-1:0] dut_word();
    return {dbg_state_o, busy, detect_add, lfd_state, ld_state, laf_state,
            full_state, rst_int_reg, write_enb_reg};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic add(input logic pv, input logic [1:0] din, input logic ff,
                     input logic [2:0] fe, input logic [2:0] sr, input logic pd,
                     input logic lpv, input state_e exp);
    vec_t v;
    v.pv = pv; v.din = din; v.ff = ff; v.fe = fe; v.sr = sr;
    v.pd = pd; v.lpv = lpv; v.exp = exp;
    tbl.push_back(v);
  endtask

  // driver: apply at negedge, score one cycle later
  task automatic drive(input vec_t v, input int idx);
    logic [W-1:0] e;
    @(negedge clk);
    pkt_valid = v.pv; data_in = v.din; fifo_full = v.ff; fifo_empty = v.fe;
    soft_reset = v.sr; parity_done = v.pd; low_pkt_valid = v.lpv;
    exp_q.push_back(expect_word(v.exp));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("vec%0d", idx), dut_word(), e);
  endtask

  task automatic idle_inputs();
    pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0; fifo_empty = 3'b111;
    soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
  endtask

  initial begin
    // addr=1, 5-byte packet, then parity
    add(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, LOAD_FIRST_DATA);
    for (int i = 0; i < 4; i++) add(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA);
    add(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, LOAD_PARITY);
    add(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, CHECK_PARITY_ERROR);
    add(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS);
    // invalid address never leaves decode
    add(1, 2'd3, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS);
    add(1, 2'd3, 0, 3'b000, 3'b000, 0, 0, DECODE_ADDRESS);
    // addr=2 waits for its FIFO to drain
    add(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, WAIT_TILL_EMPTY);
    add(1, 2'd0, 0, 3'b011, 3'b000, 0, 0, WAIT_TILL_EMPTY);
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, LOAD_FIRST_DATA);
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA);
    // full for 3 cycles, then drain with low_pkt_valid
    for (int i = 0; i < 3; i++) add(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, FIFO_FULL_STATE);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, LOAD_AFTER_FULL);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 1, LOAD_PARITY);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, CHECK_PARITY_ERROR);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS);
    // soft reset on the active port (addr=0)
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, LOAD_FIRST_DATA);
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA);
    add(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, FIFO_FULL_STATE);
    add(1, 2'd0, 1, 3'b111, 3'b001, 0, 0, DECODE_ADDRESS);
    // soft reset on another port (addr=1) is ignored; parity_done wins
    add(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, LOAD_FIRST_DATA);
    add(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA);
    add(1, 2'd1, 1, 3'b111, 3'b000, 0, 0, FIFO_FULL_STATE);
    add(1, 2'd1, 1, 3'b111, 3'b101, 0, 0, FIFO_FULL_STATE);
    add(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, LOAD_AFTER_FULL);
    add(0, 2'd1, 0, 3'b111, 3'b000, 1, 1, DECODE_ADDRESS);
    // fifo_full beats !pkt_valid in LOAD_DATA; CHECK_PARITY_ERROR into full
    add(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, LOAD_FIRST_DATA);
    add(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA);
    add(0, 2'd2, 1, 3'b111, 3'b000, 0, 0, FIFO_FULL_STATE);
    add(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, LOAD_AFTER_FULL);
    add(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA);
    add(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, LOAD_PARITY);
    add(0, 2'd2, 1, 3'b111, 3'b000, 0, 0, CHECK_PARITY_ERROR);
    add(0, 2'd2, 1, 3'b111, 3'b000, 0, 0, FIFO_FULL_STATE);
    add(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, LOAD_AFTER_FULL);
    add(0, 2'd2, 0, 3'b111, 3'b000, 1, 0, DECODE_ADDRESS);
    // soft reset while waiting for an empty FIFO (addr=1)
    add(1, 2'd1, 0, 3'b000, 3'b000, 0, 0, WAIT_TILL_EMPTY);
    add(0, 2'd1, 0, 3'b000, 3'b010, 0, 0, DECODE_ADDRESS);

    idle_inputs();
    resetn = 1'b0;
    #12;
    check("reset_state", dut_word(), expect_word(DECODE_ADDRESS));
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", dut_word(), expect_word(DECODE_ADDRESS));

    for (int i = 0; i < tbl.size(); i++) drive(tbl[i], i);

    // async reset mid-LOAD_DATA: outputs settle before the next edge
    begin
      vec_t v;
      v.pv = 1; v.din = 2'd1; v.ff = 0; v.fe = 3'b111; v.sr = 3'b000;
      v.pd = 0; v.lpv = 0; v.exp = LOAD_FIRST_DATA;
      drive(v, 100);
      v.exp = LOAD_DATA;
      drive(v, 101);
      #2;
      resetn = 1'b0;
      #1;
      check("async_reset", dut_word(), expect_word(DECODE_ADDRESS));
      @(negedge clk);
      check("reset_held", dut_word(), expect_word(DECODE_ADDRESS));
      resetn = 1'b1;
      pkt_valid = 1'b0;
      @(posedge clk);
      #1;
      check("abandoned_pkt", dut_word(), expect_word(DECODE_ADDRESS));
      // addr cleared by reset: a wait on port 0 must now track fifo_empty[0]
      v.pv = 1; v.din = 2'd0; v.fe = 3'b110; v.exp = WAIT_TILL_EMPTY;
      drive(v, 102);
      v.pv = 0; v.fe = 3'b011; v.exp = LOAD_FIRST_DATA;
      drive(v, 103);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
